// File: rtl/rf_pkg.sv
// Shared constants, slot payload type and the slot/register match helper.
package rf_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_W    = $clog2(NUM_REGS);

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } slot_t;

  // A full slot matches a read port when it targets that (non-zero) register.
  function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] id);
    return s.valid && (id != ZERO_REG) && (s.dst == id);
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback buffer: accepts on valid&&ready, empties when granted,
// reloads in the same cycle if a new entry arrives while it is being drained.
module wb_slot
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [REG_W-1:0]  i_dst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_ready,
  output logic              o_load,
  output slot_t             o_slot
);

  slot_t r_slot;
  logic  w_ready;

  // Ready depends only on state (and reset), never on this channel's valid.
  assign w_ready = rst & (~r_slot.valid | i_grant);
  assign o_ready = w_ready;
  assign o_load  = i_valid & w_ready;
  assign o_slot  = r_slot;

  // Slot register: load has priority over drain so a granted slot can reload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot <= '0;
    end else if (o_load) begin
      r_slot <= '{valid: 1'b1, dst: i_dst, data: i_data};
    end else if (i_grant) begin
      r_slot <= '0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester write-port arbiter for the register file, with oldest-first
// draining, read-after-write hazard detection and forwarding of buffered data.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_wen,
  output logic [REG_W-1:0]  rf_dst,
  output logic [DATA_W-1:0] rf_data,
  input  logic [REG_W-1:0]  src1_id,
  input  logic [REG_W-1:0]  src2_id,
  output logic              src1_hit,
  output logic              src2_hit,
  output logic [DATA_W-1:0] src1_fwd,
  output logic [DATA_W-1:0] src2_fwd,
  output logic              idle
);

  slot_t w_alu_slot;
  slot_t w_mem_slot;
  logic  w_alu_load;
  logic  w_mem_load;
  logic  w_alu_grant;
  logic  w_mem_grant;
  logic  r_mem_older;

  wb_slot u_alu_slot (
    .clk     (clk),
    .rst     (rst),
    .i_valid (alu_valid),
    .i_dst   (alu_dst),
    .i_data  (alu_data),
    .i_grant (w_alu_grant),
    .o_ready (alu_ready),
    .o_load  (w_alu_load),
    .o_slot  (w_alu_slot)
  );

  wb_slot u_mem_slot (
    .clk     (clk),
    .rst     (rst),
    .i_valid (mem_valid),
    .i_dst   (mem_dst),
    .i_data  (mem_data),
    .i_grant (w_mem_grant),
    .o_ready (mem_ready),
    .o_load  (w_mem_load),
    .o_slot  (w_mem_slot)
  );

  // Grant: a lone full slot wins; with both full the older one wins (ALU on ties).
  always_comb begin
    w_alu_grant = 1'b0;
    w_mem_grant = 1'b0;
    if (w_alu_slot.valid && w_mem_slot.valid) begin
      w_mem_grant = r_mem_older;
      w_alu_grant = ~r_mem_older;
    end else begin
      w_alu_grant = w_alu_slot.valid;
      w_mem_grant = w_mem_slot.valid;
    end
  end

  // Age bit: memory is older only if it survives an edge on which ALU reloads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_older <= 1'b0;
    end else if (w_alu_load && w_mem_load) begin
      r_mem_older <= 1'b0;
    end else if (w_alu_load) begin
      r_mem_older <= w_mem_slot.valid & ~w_mem_grant;
    end else if (w_mem_load) begin
      r_mem_older <= 1'b0;
    end
  end

  // Write port drive from the granted slot; register 0 drains without a write.
  always_comb begin
    rf_dst  = '0;
    rf_data = '0;
    if (w_alu_grant) begin
      rf_dst  = w_alu_slot.dst;
      rf_data = w_alu_slot.data;
    end else if (w_mem_grant) begin
      rf_dst  = w_mem_slot.dst;
      rf_data = w_mem_slot.data;
    end
    rf_wen = (w_alu_grant | w_mem_grant) && (rf_dst != ZERO_REG);
    idle   = ~w_alu_slot.valid & ~w_mem_slot.valid;
  end

  logic [REG_W-1:0]  w_src_id  [2];
  logic              w_src_hit [2];
  logic [DATA_W-1:0] w_src_fwd [2];

  assign w_src_id[0] = src1_id;
  assign w_src_id[1] = src2_id;

  // Hazard compare and forwarding; with two matches the younger slot wins.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic h_alu;
      logic h_mem;
      h_alu        = slot_hit(w_alu_slot, w_src_id[p]);
      h_mem        = slot_hit(w_mem_slot, w_src_id[p]);
      w_src_hit[p] = h_alu | h_mem;
      w_src_fwd[p] = '0;
      if (h_alu && h_mem) begin
        w_src_fwd[p] = r_mem_older ? w_alu_slot.data : w_mem_slot.data;
      end else if (h_alu) begin
        w_src_fwd[p] = w_alu_slot.data;
      end else if (h_mem) begin
        w_src_fwd[p] = w_mem_slot.data;
      end
    end
  end

  assign src1_hit = w_src_hit[0];
  assign src2_hit = w_src_hit[1];
  assign src1_fwd = w_src_fwd[0];
  assign src2_fwd = w_src_fwd[1];

endmodule
